// File: rtl/case_3_mul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : case_3_mul_rr_sched
// Brief    : Round-robin scheduler sharing one signed multiplier among
//            NUM_REQ requesters, with a valid/ready tagged result register.
//            Optional macro MUL_PIPE_STAGE_EN adds an operand stage (latency 2).
// Revision : 1.0 - initial release
// ============================================================================
module case_3_mul_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int DIN_W   = 4,
    parameter int DOUT_W  = 8,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*DIN_W-1:0] req_a,
    input  logic [NUM_REQ*DIN_W-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DOUT_W-1:0]        res_data,
    output logic [ID_W-1:0]          res_id,
    output logic [CNT_W-1:0]         op_count
);

    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     res_valid_q, res_valid_d;
    logic [DOUT_W-1:0]        res_data_q, res_data_d;
    logic [ID_W-1:0]          res_id_q, res_id_d;

    logic                     grant_found;
    logic [ID_W-1:0]          grant_idx;
    logic                     out_free;
    logic                     issue_free;
    logic                     accept;
    logic                     load_out;
    logic [DIN_W-1:0]         sel_a, sel_b;
    logic [DIN_W-1:0]         mul_a, mul_b;
    logic [ID_W-1:0]          mul_id;
    logic signed [DOUT_W-1:0] mul_a_ext, mul_b_ext, product;

    // First asserted request at or above the pointer, wrapping modulo NUM_REQ
    always_comb begin : grant_search
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + 32'(k);
            if (idx >= 32'(NUM_REQ)) begin
                idx = idx - 32'(NUM_REQ);
            end
            if (!grant_found && 1'(req_valid >> idx)) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    assign sel_a    = DIN_W'(req_a >> (DIN_W * int'(grant_idx)));
    assign sel_b    = DIN_W'(req_b >> (DIN_W * int'(grant_idx)));
    assign out_free = !res_valid_q || res_ready;

`ifdef MUL_PIPE_STAGE_EN
    logic             s1_valid_q, s1_valid_d;
    logic [DIN_W-1:0] s1_a_q, s1_a_d;
    logic [DIN_W-1:0] s1_b_q, s1_b_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;

    // Stage 1 moves into the output register whenever the output can take it
    assign issue_free = !s1_valid_q || out_free;
    assign load_out   = s1_valid_q && out_free;
    assign mul_a      = s1_a_q;
    assign mul_b      = s1_b_q;
    assign mul_id     = s1_id_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = sel_a;
            s1_b_d     = sel_b;
            s1_id_d    = grant_idx;
        end else if (load_out) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
        end
    end
`else
    assign issue_free = out_free;
    assign load_out   = accept;
    assign mul_a      = sel_a;
    assign mul_b      = sel_b;
    assign mul_id     = grant_idx;
`endif

    assign accept    = grant_found && issue_free && !ap_rst;
    assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

    // Operands are sign-extended to DOUT_W, so the truncated product is exact
    assign mul_a_ext = {{(DOUT_W-DIN_W){mul_a[DIN_W-1]}}, mul_a};
    assign mul_b_ext = {{(DOUT_W-DIN_W){mul_b[DIN_W-1]}}, mul_b};
    assign product   = mul_a_ext * mul_b_ext;

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q + CNT_W'(accept);
        if (load_out) begin
            res_valid_d = 1'b1;
            res_data_d  = product;
            res_id_d    = mul_id;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
        if (accept) begin
            ptr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign op_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_case_3_mul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_case_3_mul_rr_sched
// Brief    : Directed self-checking bench for the round-robin multiplier
//            scheduler (latency follows MUL_PIPE_STAGE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_case_3_mul_rr_sched;

`ifdef MUL_PIPE_STAGE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        res_ready = 1'b0;
    wire  [3:0]  req_ready;
    wire         res_valid;
    wire  [7:0]  res_data;
    wire  [1:0]  res_id;
    wire  [15:0] op_count;

    int n_err = 0;
    int n_chk = 0;

    case_3_mul_rr_sched #(
        .NUM_REQ(4), .DIN_W(4), .DOUT_W(8), .ID_W(2), .CNT_W(16)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge ap_clk);
    endtask

    // Arithmetic vectors: {a, b, expected product}
    logic [3:0] va [6] = '{4'h8, 4'h8, 4'hF, 4'h0, 4'h7, 4'hF};
    logic [3:0] vb [6] = '{4'h8, 4'h7, 4'h1, 4'h5, 4'h7, 4'hF};
    logic [7:0] vp [6] = '{8'h40, 8'hC8, 8'hFF, 8'h00, 8'h31, 8'h01};
    int sp_id [2] = '{2, 1};

    initial begin
        int bid;
        // requester i multiplies (i+1) * 2
        for (int i = 0; i < 4; i++) begin
            req_a[i*4 +: 4] = 4'(i + 1);
            req_b[i*4 +: 4] = 4'd2;
        end
        req_valid = 4'hF;
        res_ready = 1'b1;
        ap_rst    = 1'b1;
        step();
        step();
        mid();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(res_valid), 32'h0);
        check("rst_data",  32'(res_data),  32'h0);
        check("rst_id",    32'(res_id),    32'h0);
        check("rst_count", 32'(op_count),  32'h0);
        step();
        ap_rst = 1'b0;

        for (int n = 0; n < 5; n++) begin
            mid();
            check("rr_grant", 32'(req_ready), 32'(1 << (n % 4)));
            if (n >= LAT) begin
                check("rr_valid", 32'(res_valid), 32'h1);
                check("rr_id",    32'(res_id),    32'((n - LAT) % 4));
                check("rr_data",  32'(res_data),  32'(2 * ((n - LAT) % 4 + 1)));
            end
            step();
        end

        res_ready = 1'b0;
        bid = (5 - LAT) % 4;
        for (int n = 0; n < 3; n++) begin
            mid();
            check("bp_ready", 32'(req_ready), 32'h0);
            check("bp_valid", 32'(res_valid), 32'h1);
            check("bp_id",    32'(res_id),    32'(bid));
            check("bp_data",  32'(res_data),  32'(2 * (bid + 1)));
            check("bp_count", 32'(op_count),  32'd5);
            step();
        end
        res_ready = 1'b1;
        mid();
        check("rel_grant", 32'(req_ready), 32'h2);
        step();
        mid();
        check("rel_id",    32'(res_id),   32'((6 - LAT) % 4));
        check("rel_valid", 32'(res_valid), 32'h1);
        check("rel_count", 32'(op_count), 32'd6);
        req_valid = 4'h0;
        for (int n = 0; n < LAT + 1; n++) step();
        mid();
        check("drain_valid", 32'(res_valid), 32'h0);
        check("drain_count", 32'(op_count),  32'd6);

        for (int v = 0; v < 6; v++) begin
            req_a     = {4{va[v]}};
            req_b     = {4{vb[v]}};
            req_valid = 4'b0001;
            step();
            req_valid = 4'b0000;
            for (int n = 1; n < LAT; n++) step();
            mid();
            check("mul_valid", 32'(res_valid), 32'h1);
            check("mul_data",  32'(res_data),  32'(vp[v]));
        end
        check("mul_count", 32'(op_count), 32'd12);

        // pointer sits at 1 here; requester 2 then 1 must be granted back to back
        req_valid = 4'b0100;
        #1;
        check("sp_grant2", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0010;
        mid();
        check("sp_grant1", 32'(req_ready), 32'h2);
        for (int t = 1; t <= 3; t++) begin
            if (t > 1) mid();
            if (t - LAT >= 0 && t - LAT < 2) begin
                check("sp_valid", 32'(res_valid), 32'h1);
                check("sp_id",    32'(res_id),    32'(sp_id[t - LAT]));
            end else if (t - LAT >= 2) begin
                check("sp_idle", 32'(res_valid), 32'h0);
            end
            step();
            req_valid = 4'b0000;
        end
        check("sp_count", 32'(op_count), 32'd14);

        req_a     = '0;
        req_b     = '0;
        req_valid = 4'hF;
        res_ready = 1'b0;
        for (int n = 0; n < LAT; n++) step();
        mid();
        check("mr_pre_valid", 32'(res_valid), 32'h1);
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        mid();
        check("mr_valid", 32'(res_valid), 32'h0);
        check("mr_count", 32'(op_count),  32'h0);
        check("mr_grant", 32'(req_ready), 32'h1);

        res_ready = 1'b1;
        for (int n = 0; n < 65535; n++) step();
        mid();
        check("wrap_max", 32'(op_count), 32'hFFFF);
        step();
        mid();
        check("wrap_zero", 32'(op_count), 32'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
